stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch

---
 rtl/stopwatch_core_pkg.sv | 23 ++
 rtl/stopwatch_core_seg7.sv | 32 +++
 rtl/stopwatch_core.sv | 70 +++++++
 tb/tb_stopwatch_core.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_core_pkg.sv
// rtl/stopwatch_core_pkg.sv - segment constants and BCD helper shared by the stopwatch
package stopwatch_core_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int unsigned DP_BIT   = 7;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_core_seg7.sv
// rtl/stopwatch_core_seg7.sv - active-low seven-segment decoder with optional decimal point
module seg7_decoder
  import stopwatch_core_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dp_en,
  output logic [7:0] o_seg
);

  logic [7:0] w_code;

  always_comb begin
    w_code = SEG_BLANK;
    case (i_bcd)
      4'd0:    w_code = SEG_0;
      4'd1:    w_code = SEG_1;
      4'd2:    w_code = SEG_2;
      4'd3:    w_code = SEG_3;
      4'd4:    w_code = SEG_4;
      4'd5:    w_code = SEG_5;
      4'd6:    w_code = SEG_6;
      4'd7:    w_code = SEG_7;
      4'd8:    w_code = SEG_8;
      4'd9:    w_code = SEG_9;
      default: w_code = SEG_BLANK;
    endcase
  end

  // segments are active-low, so lighting the dp means clearing its bit
  assign o_seg = w_code & ~(8'(i_dp_en) << DP_BIT);

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - 00.0..99.9 s stopwatch: prescaler, BCD chain, three segment decoders
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  output logic [7:0] S0,
  output logic [7:0] S1,
  output logic [7:0] S2
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_presc;
  logic [3:0]       r_d0;
  logic [3:0]       r_d1;
  logic [3:0]       r_d2;

  logic w_tick;
  logic w_carry0;
  logic w_carry1;

  assign w_tick   = Start && (r_presc == PRESC_MAX);
  assign w_carry0 = w_tick && (r_d0 == BCD_MAX);
  assign w_carry1 = w_carry0 && (r_d1 == BCD_MAX);

  // prescaler only moves while running, so a pause keeps the partial tick
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_presc <= '0;
    end else if (Start) begin
      r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_d0 <= 4'd0;
      r_d1 <= 4'd0;
      r_d2 <= 4'd0;
    end else begin
      if (w_tick)   r_d0 <= bcd_inc(r_d0);
      if (w_carry0) r_d1 <= bcd_inc(r_d1);
      if (w_carry1) r_d2 <= bcd_inc(r_d2);
    end
  end

  seg7_decoder u_seg_tenths (
    .i_bcd   (r_d0),
    .i_dp_en (1'b0),
    .o_seg   (S0)
  );

  seg7_decoder u_seg_units (
    .i_bcd   (r_d1),
    .i_dp_en (1'b1),
    .o_seg   (S1)
  );

  seg7_decoder u_seg_tens (
    .i_bcd   (r_d2),
    .i_dp_en (1'b0),
    .o_seg   (S2)
  );

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core at TICK_DIV 1 and 4
module tb_stopwatch_core;

  logic       clk;
  logic       nreset;
  logic       start1;
  logic       start4;
  logic [7:0] s0_1, s1_1, s2_1;
  logic [7:0] s0_4, s1_4, s2_4;

  int checks;
  int errors;
  int cnt1;
  int cnt4;
  int p4;
  logic [47:0] exp_q[$];

  stopwatch_core #(.TICK_DIV(1)) dut1 (
    .Clk(clk), .nReset(nreset), .Start(start1), .S0(s0_1), .S1(s1_1), .S2(s2_1)
  );

  stopwatch_core #(.TICK_DIV(4)) dut4 (
    .Clk(clk), .nReset(nreset), .Start(start4), .S0(s0_4), .S1(s1_4), .S2(s2_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [23:0] disp_of(input int v);
    return {seg_of(v / 100), seg_of((v / 10) % 10) & 8'h7F, seg_of(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [47:0] e;
    e = exp_q.pop_front();
    check({tag, "/div1"}, {s2_1, s1_1, s0_1}, e[47:24]);
    check({tag, "/div4"}, {s2_4, s1_4, s0_4}, e[23:0]);
  endtask

  task automatic model_reset();
    cnt1 = 0;
    cnt4 = 0;
    p4   = 0;
  endtask

  // advance the reference model for one rising edge, then let the DUT take it
  task automatic step(input string tag);
    if (!nreset) begin
      model_reset();
    end else begin
      if (start1) cnt1 = (cnt1 + 1) % 1000;
      if (start4) begin
        if (p4 == 3) begin
          p4   = 0;
          cnt4 = (cnt4 + 1) % 1000;
        end else begin
          p4++;
        end
      end
    end
    exp_q.push_back({disp_of(cnt1), disp_of(cnt4)});
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nreset = 1'b0;
    start1 = 1'b1;
    start4 = 1'b1;
    model_reset();

    #1;
    exp_q.push_back({disp_of(0), disp_of(0)});
    pop_compare("reset_initial");
    check("reset_literal", {s2_1, s1_1, s0_1}, 24'hC040C0);
    for (int i = 0; i < 5; i++) step("reset_hold");

    nreset = 1'b1;
    for (int i = 0; i < 10; i++) step("run");
    check("run_one_second", {s2_1, s1_1, s0_1}, 24'hC079C0);

    start1 = 1'b0;
    start4 = 1'b0;
    step("pause1");
    for (int i = 0; i < 3; i++) step("pause_hold");

    start1 = 1'b1;
    start4 = 1'b1;
    for (int i = 0; i < 7; i++) step("resume");

    start4 = 1'b0;
    step("partial_pause4");
    start4 = 1'b1;
    for (int i = 0; i < 6; i++) step("partial_resume4");

    nreset = 1'b0;
    #2;
    model_reset();
    exp_q.push_back({disp_of(0), disp_of(0)});
    pop_compare("async_reset");
    check("async_reset_literal", {s2_4, s1_4, s0_4}, 24'hC040C0);
    nreset = 1'b1;

    for (int i = 0; i < 3; i++) step("first_tick_div4");
    for (int i = 3; i < 999; i++) step("wrap_run");
    check("wrap_99_9", {s2_1, s1_1, s0_1}, 24'h901090);
    step("wrap_edge");
    check("wrap_00_0", {s2_1, s1_1, s0_1}, 24'hC040C0);
    for (int i = 0; i < 5; i++) step("post_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
